// File: rtl/rm_lane_tracker.sv
// Per-lane event counter with a sticky fired flag and a one-cycle alert pulse.
// Define RM_TIMEOUT_EN to let an idle COUNTING lane expire after WINDOW cycles.
module rm_lane_tracker #(
    parameter int NUM_LANES = 5,
    parameter int THRESHOLD = 3,
    parameter int WINDOW    = 16,
    localparam int LANE_W   = $clog2(NUM_LANES),
    localparam int CNT_W    = $clog2(THRESHOLD + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 probe_val_i,
    input  logic [LANE_W-1:0]    lane_i,
    input  logic                 reset_lane_i,
    input  logic                 clear_all_i,
    input  logic [LANE_W-1:0]    rd_lane_i,
    output logic                 alert_o,
    output logic [LANE_W-1:0]    alert_lane_o,
    output logic [NUM_LANES-1:0] lane_fired_o,
    output logic [CNT_W-1:0]     rd_count_o
);

    typedef enum logic [1:0] {
        IDLE,
        COUNTING,
        FIRED
    } lane_state_e;

    lane_state_e          state_q [NUM_LANES];
    lane_state_e          state_d [NUM_LANES];
    logic [CNT_W-1:0]     cnt_q   [NUM_LANES];
    logic [CNT_W-1:0]     cnt_d   [NUM_LANES];
    logic [NUM_LANES-1:0] fired_q;
    logic [NUM_LANES-1:0] fired_d;
    logic                 alert_q;
    logic                 alert_d;
    logic [LANE_W-1:0]    alert_lane_q;
    logic [LANE_W-1:0]    alert_lane_d;

`ifdef RM_TIMEOUT_EN
    localparam int TMR_W = $clog2(WINDOW + 1);
    logic [TMR_W-1:0] tmr_q [NUM_LANES];
    logic [TMR_W-1:0] tmr_d [NUM_LANES];
`else
    logic unused_window;
    assign unused_window = (WINDOW != 0);
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fired_d      = fired_q;
        alert_d      = 1'b0;
        alert_lane_d = alert_lane_q;
`ifdef RM_TIMEOUT_EN
        tmr_d        = tmr_q;
`endif
        // Out-of-range lane_i matches no lane, so its probe/reset are dropped.
        for (int l = 0; l < NUM_LANES; l++) begin
            if (clear_all_i || (reset_lane_i && lane_i == LANE_W'(l))) begin
                state_d[l] = IDLE;
                cnt_d[l]   = '0;
                fired_d[l] = 1'b0;
`ifdef RM_TIMEOUT_EN
                tmr_d[l]   = '0;
`endif
            end else if (probe_val_i && lane_i == LANE_W'(l)
                         && state_q[l] != FIRED) begin
                cnt_d[l] = cnt_q[l] + CNT_W'(1);
`ifdef RM_TIMEOUT_EN
                tmr_d[l] = TMR_W'(WINDOW);
`endif
                if (cnt_q[l] == CNT_W'(THRESHOLD - 1)) begin
                    state_d[l]   = FIRED;
                    fired_d[l]   = 1'b1;
                    alert_d      = 1'b1;
                    alert_lane_d = LANE_W'(l);
                end else begin
                    state_d[l] = COUNTING;
                end
            end
`ifdef RM_TIMEOUT_EN
            else if (state_q[l] == COUNTING) begin
                // The decrement that reaches zero also drops the lane.
                if (tmr_q[l] <= TMR_W'(1)) begin
                    state_d[l] = IDLE;
                    cnt_d[l]   = '0;
                    tmr_d[l]   = '0;
                end else begin
                    tmr_d[l] = tmr_q[l] - TMR_W'(1);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                state_q[l] <= IDLE;
                cnt_q[l]   <= '0;
`ifdef RM_TIMEOUT_EN
                tmr_q[l]   <= '0;
`endif
            end
            fired_q      <= '0;
            alert_q      <= 1'b0;
            alert_lane_q <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                state_q[l] <= state_d[l];
                cnt_q[l]   <= cnt_d[l];
`ifdef RM_TIMEOUT_EN
                tmr_q[l]   <= tmr_d[l];
`endif
            end
            fired_q      <= fired_d;
            alert_q      <= alert_d;
            alert_lane_q <= alert_lane_d;
        end
    end

    always_comb begin
        rd_count_o = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (rd_lane_i == LANE_W'(l)) begin
                rd_count_o = cnt_q[l];
            end
        end
    end

    assign alert_o      = alert_q;
    assign alert_lane_o = alert_lane_q;
    assign lane_fired_o = fired_q;

endmodule

// File: tb/tb_rm_lane_tracker.sv
// Directed bench for rm_lane_tracker checked against a count-level lane model.
// Timeout scenarios are exercised when RM_TIMEOUT_EN is defined.
module tb_rm_lane_tracker;

    localparam int NL  = 5;
    localparam int THR = 3;
    localparam int WIN = 4;
`ifdef RM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       probe_val_i = 1'b0;
    logic [2:0] lane_i = 3'd0;
    logic       reset_lane_i = 1'b0;
    logic       clear_all_i = 1'b0;
    logic [2:0] rd_lane_i = 3'd0;
    logic       alert_o;
    logic [2:0] alert_lane_o;
    logic [4:0] lane_fired_o;
    logic [1:0] rd_count_o;

    rm_lane_tracker #(
        .NUM_LANES(NL),
        .THRESHOLD(THR),
        .WINDOW   (WIN)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .probe_val_i (probe_val_i),
        .lane_i      (lane_i),
        .reset_lane_i(reset_lane_i),
        .clear_all_i (clear_all_i),
        .rd_lane_i   (rd_lane_i),
        .alert_o     (alert_o),
        .alert_lane_o(alert_lane_o),
        .lane_fired_o(lane_fired_o),
        .rd_count_o  (rd_count_o)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int m_cnt   [NL];
    int m_tmr   [NL];
    bit m_fired [NL];
    bit m_alert;
    int m_alert_lane;

    function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] fired_vec();
        logic [31:0] v = 0;
        for (int l = 0; l < NL; l++) v[l] = m_fired[l];
        return v;
    endfunction

    // One clock edge of the lane rules, expressed on counts only.
    function automatic void model_edge(bit p, int ln, bit rl, bit ca, bit r);
        m_alert = 1'b0;
        if (r) m_alert_lane = 0;
        for (int l = 0; l < NL; l++) begin
            if (r || ca || (rl && ln == l)) begin
                m_cnt[l] = 0;
                m_tmr[l] = 0;
                m_fired[l] = 1'b0;
            end else if (p && ln == l) begin
                if (m_cnt[l] < THR) begin
                    m_cnt[l]++;
                    m_tmr[l] = WIN;
                    if (m_cnt[l] == THR) begin
                        m_fired[l] = 1'b1;
                        m_alert = 1'b1;
                        m_alert_lane = l;
                    end
                end
            end else if (TO_EN && m_cnt[l] > 0 && m_cnt[l] < THR) begin
                m_tmr[l]--;
                if (m_tmr[l] == 0) m_cnt[l] = 0;
            end
        end
    endfunction

    task automatic step(input bit p, input int ln, input bit rl = 0,
                        input bit ca = 0, input bit r = 0);
        probe_val_i  = p;
        lane_i       = ln[2:0];
        reset_lane_i = rl;
        clear_all_i  = ca;
        rst_i        = r;
        @(posedge clk);
        model_edge(p, ln, rl, ca, r);
        #1;
        probe_val_i  = 1'b0;
        reset_lane_i = 1'b0;
        clear_all_i  = 1'b0;
        rst_i        = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("alert_o", 32'(alert_o), 32'(m_alert));
            cmp("alert_lane_o", 32'(alert_lane_o), 32'(m_alert_lane));
            cmp("lane_fired_o", 32'(lane_fired_o), fired_vec());
            for (int l = 0; l < 8; l++) begin
                rd_lane_i = l[2:0];
                #1;
                cmp($sformatf("rd_count lane%0d", l), 32'(rd_count_o),
                    32'(l < NL ? m_cnt[l] : 0));
            end
        end
    end

    initial begin
        for (int l = 0; l < NL; l++) begin
            m_cnt[l] = 0;
            m_tmr[l] = 0;
            m_fired[l] = 1'b0;
        end
        m_alert = 1'b0;
        m_alert_lane = 0;

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk_en = 1'b1;
        cmp("reset alert", 32'(alert_o), 0);
        cmp("reset fired", 32'(lane_fired_o), 0);

        step(1, 2); step(0, 0);
        step(1, 2); step(0, 0);
        cmp("lane2 model cnt2", 32'(m_cnt[2]), 2);
        step(1, 2);
        cmp("lane2 alert", 32'(alert_o), 1);
        cmp("lane2 alert_lane", 32'(alert_lane_o), 2);
        cmp("lane2 fired", 32'(lane_fired_o), 32'b00100);
        cmp("lane2 model cnt3", 32'(m_cnt[2]), 3);
        step(0, 0);
        cmp("alert one cycle", 32'(alert_o), 0);

        step(1, 2);
        cmp("fired probe no alert a", 32'(alert_o), 0);
        step(1, 2);
        cmp("fired probe no alert b", 32'(alert_o), 0);
        cmp("lane2 saturate", 32'(m_cnt[2]), 3);
        step(0, 2, 1);
        cmp("lane2 reset fired", 32'(lane_fired_o), 0);
        cmp("lane2 reset cnt", 32'(m_cnt[2]), 0);

        step(1, 1); step(1, 1);
        step(1, 1, 1);
        cmp("rl beats probe alert", 32'(alert_o), 0);
        cmp("rl beats probe cnt", 32'(m_cnt[1]), 0);
        step(1, 3);
        cmp("lane3 cnt1", 32'(m_cnt[3]), 1);

        step(1, 0); step(1, 4); step(1, 0); step(1, 4); step(1, 0);
        cmp("lane0 alert", 32'(alert_o), 1);
        cmp("lane0 alert_lane", 32'(alert_lane_o), 0);
        cmp("lane4 cnt2", 32'(m_cnt[4]), 2);
        step(1, 5);
        cmp("lane5 ignored fired", 32'(lane_fired_o), 32'b00001);
        cmp("lane5 ignored alert", 32'(alert_o), 0);

        step(0, 3, 1);
        step(1, 2); step(1, 2); step(1, 2);
        step(1, 3);
        cmp("pre-clear fired", 32'(lane_fired_o), 32'b00101);
        cmp("pre-clear alert_lane", 32'(alert_lane_o), 2);
        step(1, 3, 0, 1);
        cmp("clear fired", 32'(lane_fired_o), 0);
        cmp("clear alert", 32'(alert_o), 0);
        cmp("clear lane3", 32'(m_cnt[3]), 0);

        step(1, 1);
        repeat (4) step(0, 0);
        cmp("window expiry", 32'(m_cnt[1]), TO_EN ? 0 : 1);
        step(0, 1, 1);
        step(1, 1);
        repeat (3) step(0, 0);
        step(1, 1);
        cmp("probe wins at timer 1", 32'(m_cnt[1]), 2);
        repeat (6) step(0, 0);

        step(0, 4, 1);
        step(1, 4); step(1, 4);
        step(1, 4, 0, 0, 1);
        cmp("reset suppresses alert", 32'(alert_o), 0);
        cmp("reset clears alert_lane", 32'(alert_lane_o), 0);
        step(0, 0);
        step(0, 0);

        chk_en = 1'b0;
        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
